global_avg_pool: RTL
====================

# global_avg_pool

Global average pooling stage placed directly upstream of the fully-connected classifier. It consumes the final residual-stage feature map as a serial channel-interleaved stream (all channels of pixel 0, then all channels of pixel 1, …), accumulates one sum per channel in block RAM, and emits one averaged value per channel on a frame-framed serial stream. That stream matches the classifier's input protocol: a `vsync` pulse, then exactly `SIZE_C` `valid` words with no backpressure.

## Interface
- `WIDTH_I`, 20: signed input activation width.
- `WIDTH_D`, 27: signed output width; must be ≥ `WIDTH_I`.
- `SIZE_C`, 512: channels per pixel; must be ≥ 4.
- `SIZE_HW`, 49: pixels per frame (7×7).
- `SHIFT`, 16: reciprocal fractional bits.
- `RECIP`, 1337: unsigned round(2^SHIFT / SIZE_HW).
- `i_sclk`, in, 1: clock. One clock; reset is synchronous and active-high.
- `i_rstp`, in, 1: synchronous active-high reset.
- `i_vsync`, in, 1: frame-start pulse.
- `i_valid`, in, 1: input word strobe.
- `i_tdata`, in, `WIDTH_I`: signed activation.
- `o_vsync`, out, 1: output frame-start pulse, feeds classifier `i_vsync`.
- `o_valid`, out, 1: output word strobe.
- `o_tdata`, out, `WIDTH_D`: signed channel average.
- `o_overrun`, out, 1: sticky flag, set when a drain is aborted; cleared only by `i_rstp`.

## Operation
- Sum width `WIDTH_S = WIDTH_I + $clog2(SIZE_HW)` (26 bits), signed. No overflow is possible.
- Counters: `ch_cnt` runs 0..`SIZE_C`-1 and wraps to 0. `pix_cnt` runs 0..`SIZE_HW`-1 and increments on the `ch_cnt` wrap.
- States are IDLE, ACC, FLUSH, DRAIN.
- IDLE: `i_valid` is ignored.
- `i_vsync` in any state moves to ACC and zeroes both counters. An `i_valid` in the same cycle is accepted as channel 0, pixel 0.
- ACC, per accepted word:
  - Read RAM[`ch_cnt`].
  - If `pix_cnt`==0, write `i_tdata` (sign-extended) to RAM[`ch_cnt`]; otherwise write the read sum plus `i_tdata`. No clear pass is needed.
  - After the word with `ch_cnt`=`SIZE_C`-1 and `pix_cnt`=`SIZE_HW`-1 is accepted, go to FLUSH.
- FLUSH: lasts 2 cycles while the final write retires; `i_valid` is ignored. Then go to DRAIN.
- DRAIN:
  - On entry, `o_vsync` pulses for 1 cycle.
  - Read addresses 0..`SIZE_C`-1 at one per cycle, then return to IDLE.
  - Each sum is computed as `(sum*RECIP + 2^(SHIFT-1)) >>> SHIFT`, an arithmetic shift (floor), then sign-extended to `WIDTH_D`.
  - `i_valid` without `i_vsync` is ignored.
- `i_vsync` during DRAIN or in the output pipeline:
  - Read-out stops at once and `o_valid` is forced low from the next cycle.
  - `o_overrun` is set and the new frame is accumulated normally.
- `i_vsync` mid-ACC: the partial frame is discarded. This is safe because of the `pix_cnt`==0 overwrite rule.

## Timing
- Reset values: `o_vsync`=0, `o_valid`=0, `o_tdata`=0, `o_overrun`=0. State is IDLE and all counters are 0. RAM contents are don't-care.
- Accumulate pipeline, for a word accepted in cycle t:
  - RAM read issued at t, data available at t+1.
  - Add at t+1, write at t+2.
  - A same-address reread is ≥`SIZE_C` cycles away, so there is no hazard.
- Input may be back-to-back or gapped, at any rate.
- Let T be the cycle the last word of a frame is accepted:
  - FLUSH covers T+1..T+2.
  - `o_vsync`=1 at T+3, and read address 0 is issued at T+3.
  - Channel k appears with `o_valid`=1 at T+6+k.
  - The 512 valid words are contiguous, and `o_valid` drops at T+6+`SIZE_C`.
- Minimum throughput gap: the next `i_vsync` must arrive no earlier than T+6+`SIZE_C` to avoid overrun.

## Structure
- Package `gap_pkg` holds:
  - the state enum;
  - the `WIDTH_S` derivation;
  - the `RECIP` default computed by a constant function of `SHIFT` and `SIZE_HW`.
- One sub-module, `gap_acc_ram`: simple dual-port RAM, `SIZE_C`×`WIDTH_S`, read latency 1, one write port and one read port. It wraps `xpm_memory_sdpram`.
- The multiplier is a registered DSP stage (sum reg → product reg → round reg), 3 stages after RAM data.

## Test plan
- Constant frame: all words = 1000 → `o_vsync` at T+3, then 512 words all 1000 at T+6..T+517.
- Constant frame: all words = −1000 → 512 words all −1000, confirming floor rounding of −999.15.
- Ramp: channel c value = c for every pixel → output k = k for k = 0..511 (k=511: 33509911>>16 = 511).
- Abort mid-ACC: `i_vsync` after 10 pixels, then a full frame of 7 → 512 outputs of 7, with no residue from the aborted frame.
- Overrun: `i_vsync` plus a new frame at output channel 100 → `o_valid` low the next cycle, `o_overrun`=1, and the next frame still drains correctly.
- Reset mid-DRAIN: `i_rstp` for 1 cycle → all outputs 0 the next cycle and state IDLE. `i_valid` is ignored until `i_vsync`.

Source files
------------

// File: rtl/gap_pkg.sv
// Shared state type and parameter derivations for the global average pooling stage.
package gap_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FLUSH, S_DRAIN} gap_state_e;

  function automatic int sum_width(input int width_i, input int size_hw);
    return width_i + $clog2(size_hw);
  endfunction

  // round(2^shift / size_hw) in integer arithmetic
  function automatic int recip_calc(input int shift, input int size_hw);
    return ((1 << shift) + size_hw / 2) / size_hw;
  endfunction

  // Product must hold sum*recip and still expose WIDTH_D bits above the fraction
  function automatic int prod_width(input int width_s, input int width_d, input int shift);
    return (width_s + shift + 2 > width_d + shift + 1) ? width_s + shift + 2
                                                       : width_d + shift + 1;
  endfunction
endpackage

// File: rtl/gap_acc_ram.sv
// Simple dual-port per-channel accumulator RAM: one write port, one read port, read latency 1.
// Behavioural equivalent of the xpm_memory_sdpram configuration (no output reset, no init).
module gap_acc_ram #(
  parameter  int DEPTH = 512,
  parameter  int WIDTH = 26,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/global_avg_pool.sv
// Global average pooling: per-channel sums accumulated in RAM across a frame, then
// drained once through a reciprocal multiply as a vsync-framed stream.
module global_avg_pool
  import gap_pkg::*;
#(
  parameter int WIDTH_I = 20,
  parameter int WIDTH_D = 27,
  parameter int SIZE_C  = 512,
  parameter int SIZE_HW = 49,
  parameter int SHIFT   = 16,
  parameter int RECIP   = recip_calc(SHIFT, SIZE_HW)
) (
  input  logic               i_sclk,
  input  logic               i_rstp,
  input  logic               i_vsync,
  input  logic               i_valid,
  input  logic [WIDTH_I-1:0] i_tdata,
  output logic               o_vsync,
  output logic               o_valid,
  output logic [WIDTH_D-1:0] o_tdata,
  output logic               o_overrun
);
  localparam int WIDTH_S = sum_width(WIDTH_I, SIZE_HW);
  localparam int WIDTH_P = prod_width(WIDTH_S, WIDTH_D, SHIFT);
  localparam int AW      = $clog2(SIZE_C);
  localparam int PW      = (SIZE_HW > 1) ? $clog2(SIZE_HW) : 1;
  localparam int STAGES  = 2;
  localparam logic [AW-1:0]             CH_LAST  = AW'(SIZE_C - 1);
  localparam logic [PW-1:0]             PIX_LAST = PW'(SIZE_HW - 1);
  localparam logic [SHIFT:0]            RECIP_V  = (SHIFT+1)'(RECIP);
  localparam logic signed [WIDTH_P-1:0] HALF     = WIDTH_P'(1) << (SHIFT - 1);

  gap_state_e      r_state;
  logic [AW-1:0]   r_ch_cnt;
  logic [PW-1:0]   r_pix_cnt;
  logic            r_flush;
  logic [STAGES:0] r_vld_pipe;

  logic            w_acc, w_rd_issue, w_ch_last, w_pix_last, w_pix0;
  logic [AW-1:0]   w_ch, w_raddr;
  logic [PW-1:0]   w_pix;

  logic               r_a_vld, r_a_pix0, r_w_en;
  logic [AW-1:0]      r_a_addr, r_w_addr;
  logic [WIDTH_I-1:0] r_a_data;
  logic [WIDTH_S-1:0] r_w_data, w_rdata, w_a_ext;

  logic signed [WIDTH_P-1:0] w_mul_a, w_mul_b, w_rnd, r_prod;
  logic                      w_unused;

  // A vsync restarts the counters in the same cycle, so its companion word is ch 0 / pix 0
  always_comb begin
    w_ch       = i_vsync ? '0 : r_ch_cnt;
    w_pix      = i_vsync ? '0 : r_pix_cnt;
    w_acc      = i_valid && (i_vsync || r_state == S_ACC);
    w_ch_last  = (w_ch == CH_LAST);
    w_pix_last = (w_pix == PIX_LAST);
    w_pix0     = (w_pix == '0);
    w_rd_issue = (r_state == S_DRAIN) && !i_vsync;
    w_raddr    = w_rd_issue ? r_ch_cnt : w_ch;
  end

  always_ff @(posedge i_sclk) begin
    if (i_rstp) begin
      r_state    <= S_IDLE;
      r_ch_cnt   <= '0;
      r_pix_cnt  <= '0;
      r_flush    <= 1'b0;
      r_vld_pipe <= '0;
      o_vsync    <= 1'b0;
      o_tdata    <= '0;
      o_overrun  <= 1'b0;
    end else begin
      o_vsync    <= 1'b0;
      r_vld_pipe <= i_vsync ? '0 : {r_vld_pipe[STAGES-1:0], w_rd_issue};
      if (r_vld_pipe[STAGES-1]) o_tdata <= w_rnd[SHIFT +: WIDTH_D];
      if (i_vsync) begin
        r_state   <= S_ACC;
        r_ch_cnt  <= '0;
        r_pix_cnt <= '0;
        if (r_state == S_DRAIN || |r_vld_pipe) o_overrun <= 1'b1;
      end
      if (w_acc) begin
        r_ch_cnt <= w_ch_last ? '0 : w_ch + 1'b1;
        if (w_ch_last) r_pix_cnt <= w_pix_last ? '0 : w_pix + 1'b1;
        if (w_ch_last && w_pix_last) begin
          r_state <= S_FLUSH;
          r_flush <= 1'b0;
        end
      end else if (!i_vsync) begin
        case (r_state)
          S_FLUSH: begin
            if (r_flush) begin
              r_state <= S_DRAIN;
              o_vsync <= 1'b1;
            end else begin
              r_flush <= 1'b1;
            end
          end
          S_DRAIN: begin
            if (r_ch_cnt == CH_LAST) begin
              r_ch_cnt <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_ch_cnt <= r_ch_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_valid = r_vld_pipe[STAGES];

  // Read at t, add at t+1, write at t+2; a same-channel reread is SIZE_C words later
  always_ff @(posedge i_sclk) begin
    if (i_rstp) begin
      r_a_vld <= 1'b0;
      r_w_en  <= 1'b0;
    end else begin
      r_a_vld <= w_acc;
      r_w_en  <= r_a_vld;
    end
  end

  assign w_a_ext = {{(WIDTH_S-WIDTH_I){r_a_data[WIDTH_I-1]}}, r_a_data};

  always_ff @(posedge i_sclk) begin
    r_a_addr <= w_ch;
    r_a_pix0 <= w_pix0;
    r_a_data <= i_tdata;
    r_w_addr <= r_a_addr;
    r_w_data <= r_a_pix0 ? w_a_ext : w_rdata + w_a_ext;
  end

  gap_acc_ram #(
    .DEPTH (SIZE_C),
    .WIDTH (WIDTH_S)
  ) u_ram (
    .i_clk   (i_sclk),
    .i_we    (r_w_en),
    .i_waddr (r_w_addr),
    .i_wdata (r_w_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // RAM output register is the sum stage; then product reg, then rounded o_tdata
  assign w_mul_a = {{(WIDTH_P-WIDTH_S){w_rdata[WIDTH_S-1]}}, w_rdata};
  assign w_mul_b = {{(WIDTH_P-SHIFT-1){1'b0}}, RECIP_V};

  always_ff @(posedge i_sclk) r_prod <= w_mul_a * w_mul_b;

  assign w_rnd    = r_prod + HALF;
  assign w_unused = ^{w_rnd[SHIFT-1:0], w_rnd[WIDTH_P-1:SHIFT+WIDTH_D]};
endmodule
